// File: rtl/eco32_core_fpu_pkg.sv
// Shared constants, write-back packet layout and float helpers for the
// eco32 FPU side pipe.
package eco32_core_fpu_pkg;

  localparam int FPU_DEPTH_MIN = 3;
  localparam int FPU_DEPTH_MAX = 8;

  localparam logic [3:0] OP_FMOV = 4'd0;
  localparam logic [3:0] OP_FNEG = 4'd1;
  localparam logic [3:0] OP_FABS = 4'd2;
  localparam logic [3:0] OP_FMIN = 4'd3;
  localparam logic [3:0] OP_FMAX = 4'd4;
  localparam logic [3:0] OP_FCEQ = 4'd5;
  localparam logic [3:0] OP_FCLT = 4'd6;
  localparam logic [3:0] OP_FCLE = 4'd7;

  localparam logic [31:0] FPU_CANON_NAN = 32'h7FC0_0000;

  // Payload is all-zero unless a visible write-back is carried; tid is
  // kept for every valid entry so the retire counter knows the thread.
  typedef struct packed {
    logic        tid;
    logic        stb;
    logic [1:0]  ena_a;
    logic [1:0]  ena_b;
    logic        tag_a;
    logic        tag_b;
    logic [4:0]  addr;
    logic [31:0] data;
  } fpu_wb_pkt_t;

  function automatic logic f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Maps a non-NaN float to an unsigned key with the same ordering
  // (with -0 just below +0), so one unsigned compare orders any pair.
  function automatic logic [31:0] f_order_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

endpackage

// File: rtl/eco32_core_fpu_pipe_if.sv
// Issue and write-back bundle between the IDU, the FPU pipe and the
// register-file write ports.
interface eco32_core_fpu_pipe_if #(
  parameter int CNT_W = 4
);
  // i_stb is a single-cycle valid with no ready: the pipe accepts every
  // qualified strobe and the write-back strobes are never back-pressured.
  logic             i_stb;
  logic             i_tid;
  logic [3:0]       i_op;
  logic [31:0]      i_r0_data;
  logic [31:0]      i_r1_data;
  logic [1:0]       i_ry_ena;
  logic [4:0]       i_ry_addr;
  logic [1:0]       i_ry_tag;
  logic             fci_inst_rep;
  logic             fci_inst_skip;
  logic             fci_inst_lsf;

  logic             wb_stb0;
  logic             wb_stb1;
  logic [1:0]       wb_enaA;
  logic             wb_tagA;
  logic [1:0]       wb_enaB;
  logic             wb_tagB;
  logic             wb_modB;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_dataL;
  logic [31:0]      wb_dataH;

  logic [CNT_W-1:0] o_pendA;
  logic [CNT_W-1:0] o_pendB;
  logic             o_busyA;
  logic             o_busyB;
  logic             o_ill;

  modport master (
    output i_stb, i_tid, i_op, i_r0_data, i_r1_data,
           i_ry_ena, i_ry_addr, i_ry_tag,
           fci_inst_rep, fci_inst_skip, fci_inst_lsf,
    input  wb_stb0, wb_stb1, wb_enaA, wb_tagA, wb_enaB, wb_tagB, wb_modB,
           wb_addr, wb_dataL, wb_dataH,
           o_pendA, o_pendB, o_busyA, o_busyB, o_ill
  );

  modport slave (
    input  i_stb, i_tid, i_op, i_r0_data, i_r1_data,
           i_ry_ena, i_ry_addr, i_ry_tag,
           fci_inst_rep, fci_inst_skip, fci_inst_lsf,
    output wb_stb0, wb_stb1, wb_enaA, wb_tagA, wb_enaB, wb_tagB, wb_modB,
           wb_addr, wb_dataL, wb_dataH,
           o_pendA, o_pendB, o_busyA, o_busyB, o_ill
  );

endinterface

// File: rtl/eco32_core_fpu_dly.sv
// N-stage register delay with a valid bit per stage; data is zeroed in any
// stage that holds no valid entry.
module eco32_core_fpu_dly #(
  parameter int W = 32,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic [N:0]   v_c;
  logic [W-1:0] d_c [N+1];

  assign v_c[0] = valid_i;
  assign d_c[0] = data_i;

  for (genvar g = 0; g < N; g++) begin : g_stage
    logic         v_q;
    logic [W-1:0] d_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= v_c[g];
        d_q <= v_c[g] ? d_c[g] : '0;
      end
    end

    assign v_c[g+1] = v_q;
    assign d_c[g+1] = d_q;
  end

  assign valid_o = v_c[N];
  assign data_o  = d_c[N];

endmodule

// File: rtl/eco32_core_fpu_pipe.sv
// Fixed-latency FPU side pipe: sign ops, min/max and compares on two
// hardware threads, with per-thread in-flight counters.
module eco32_core_fpu_pipe
  import eco32_core_fpu_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  eco32_core_fpu_pipe_if.slave  fpu
);

  if (DEPTH < FPU_DEPTH_MIN || DEPTH > FPU_DEPTH_MAX) begin : g_depth_chk
    $error("eco32_core_fpu_pipe: DEPTH must be within 3..8");
  end
  if (CNT_W < $clog2(DEPTH + 1)) begin : g_cnt_chk
    $error("eco32_core_fpu_pipe: CNT_W too narrow for DEPTH");
  end

  // Stage 0: capture
  logic        s0_take, s0_v_d, ill_d;
  logic        s0_v_q, s0_tid_q, ill_q;
  logic [3:0]  s0_op_q;
  logic [31:0] s0_a_q, s0_b_q;
  logic [1:0]  s0_ena_q, s0_tag_q;
  logic [4:0]  s0_addr_q;

  assign s0_take = fpu.i_stb && !fpu.fci_inst_rep && !fpu.fci_inst_skip;
  assign s0_v_d  = s0_take && !fpu.i_op[3];
  assign ill_d   = s0_take && fpu.i_op[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v_q    <= 1'b0;
      s0_tid_q  <= 1'b0;
      s0_op_q   <= 4'd0;
      s0_a_q    <= 32'd0;
      s0_b_q    <= 32'd0;
      s0_ena_q  <= 2'd0;
      s0_tag_q  <= 2'd0;
      s0_addr_q <= 5'd0;
      ill_q     <= 1'b0;
    end else begin
      s0_v_q    <= s0_v_d;
      s0_tid_q  <= fpu.i_tid;
      s0_op_q   <= fpu.i_op;
      s0_a_q    <= fpu.i_r0_data;
      s0_b_q    <= fpu.i_r1_data;
      s0_ena_q  <= fpu.i_ry_ena;
      s0_tag_q  <= fpu.i_ry_tag;
      s0_addr_q <= fpu.i_ry_addr;
      ill_q     <= ill_d;
    end
  end

  // Stage 1: execute. key_lt is the single ordering comparator shared by
  // min/max and the compares; zeros and NaNs are patched around it.
  logic        a_nan, b_nan, any_nan, both_zero, bits_eq, key_lt;
  logic [31:0] res;

  assign a_nan     = f_is_nan(s0_a_q);
  assign b_nan     = f_is_nan(s0_b_q);
  assign any_nan   = a_nan || b_nan;
  assign both_zero = (s0_a_q[30:0] == 31'd0) && (s0_b_q[30:0] == 31'd0);
  assign bits_eq   = (s0_a_q == s0_b_q);
  assign key_lt    = f_order_key(s0_a_q) < f_order_key(s0_b_q);

  always_comb begin
    res = 32'd0;
    case (s0_op_q)
      OP_FMOV: res = s0_a_q;
      OP_FNEG: res = {~s0_a_q[31], s0_a_q[30:0]};
      OP_FABS: res = {1'b0, s0_a_q[30:0]};
      OP_FMIN, OP_FMAX: begin
        if (a_nan && b_nan)              res = FPU_CANON_NAN;
        else if (a_nan)                  res = s0_b_q;
        else if (b_nan)                  res = s0_a_q;
        else if (key_lt == (s0_op_q == OP_FMIN)) res = s0_a_q;
        else                             res = s0_b_q;
      end
      OP_FCEQ: res = {31'd0, !any_nan && (bits_eq || both_zero)};
      OP_FCLT: res = {31'd0, !any_nan && key_lt && !both_zero};
      OP_FCLE: res = {31'd0, !any_nan && (key_lt || bits_eq || both_zero)};
      default: res = 32'd0;
    endcase
  end

  logic        s1_v_d, s1_v_q, kill_v;
  fpu_wb_pkt_t s1_pkt_d, s1_pkt_q;

  assign kill_v = s0_v_q && fpu.fci_inst_lsf;
  assign s1_v_d = s0_v_q && !fpu.fci_inst_lsf;

  always_comb begin
    s1_pkt_d = '0;
    if (s1_v_d) begin
      s1_pkt_d.tid = s0_tid_q;
      if (|s0_ena_q) begin
        s1_pkt_d.stb   = 1'b1;
        s1_pkt_d.ena_a = s0_tid_q ? 2'b00 : s0_ena_q;
        s1_pkt_d.ena_b = s0_tid_q ? s0_ena_q : 2'b00;
        s1_pkt_d.tag_a = s0_tag_q[0];
        s1_pkt_d.tag_b = s0_tag_q[1];
        s1_pkt_d.addr  = s0_addr_q;
        s1_pkt_d.data  = res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_pkt_q <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_pkt_q <= s1_pkt_d;
    end
  end

  // Stages 2..DEPTH-1; the last stage register drives write-back directly.
  logic        last_v;
  fpu_wb_pkt_t last_pkt;

  eco32_core_fpu_dly #(
    .W ($bits(fpu_wb_pkt_t)),
    .N (DEPTH - 2)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .valid_i (s1_v_q),
    .data_i  (s1_pkt_q),
    .valid_o (last_v),
    .data_o  (last_pkt)
  );

  // In-flight counters: +1 on capture, -1 on stage-1 kill, -1 on retire.
  logic [CNT_W-1:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d;

  function automatic logic [CNT_W-1:0] f_pend_next(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec_kill,
    input logic             dec_ret
  );
    return cur + {{(CNT_W-1){1'b0}}, inc}
               - {{(CNT_W-1){1'b0}}, dec_kill}
               - {{(CNT_W-1){1'b0}}, dec_ret};
  endfunction

  assign pend_a_d = f_pend_next(pend_a_q, s0_v_d && !fpu.i_tid,
                                kill_v && !s0_tid_q, last_v && !last_pkt.tid);
  assign pend_b_d = f_pend_next(pend_b_q, s0_v_d && fpu.i_tid,
                                kill_v && s0_tid_q, last_v && last_pkt.tid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_a_q <= '0;
      pend_b_q <= '0;
    end else begin
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end

  assign fpu.wb_stb0  = last_pkt.stb;
  assign fpu.wb_stb1  = last_pkt.stb;
  assign fpu.wb_enaA  = last_pkt.ena_a;
  assign fpu.wb_tagA  = last_pkt.tag_a;
  assign fpu.wb_enaB  = last_pkt.ena_b;
  assign fpu.wb_tagB  = last_pkt.tag_b;
  assign fpu.wb_modB  = 1'b0;
  assign fpu.wb_addr  = last_pkt.addr;
  assign fpu.wb_dataL = last_pkt.data;
  assign fpu.wb_dataH = 32'd0;
  assign fpu.o_pendA  = pend_a_q;
  assign fpu.o_pendB  = pend_b_q;
  assign fpu.o_busyA  = (pend_a_q != '0);
  assign fpu.o_busyB  = (pend_b_q != '0);
  assign fpu.o_ill    = ill_q;

endmodule

// File: tb/tb_eco32_core_fpu_pipe.sv
// Bench for eco32_core_fpu_pipe: two lanes (DEPTH 3 and 8) share one
// stimulus stream; a monitor per lane checks against a float-rule model.
module tb_eco32_core_fpu_pipe;
  import eco32_core_fpu_pkg::*;

  localparam int NE = 4096;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Shared stimulus
  logic        stb = 0, tid = 0, rep = 0, skip = 0, lsf = 0;
  logic [3:0]  op = 0;
  logic [31:0] ra = 0, rb = 0;
  logic [1:0]  ena = 0, tag = 0;
  logic [4:0]  addr = 0;

  typedef struct packed {
    logic [31:0] e;
    logic [1:0]  ena_a;
    logic [1:0]  ena_b;
    logic        tag_a;
    logic        tag_b;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q3[$];
  exp_t exp_q8[$];

  // One record per capture edge: what was accepted and what happened to it.
  typedef struct {
    bit          acc;
    bit          kill;
    bit          ill;
    bit          tid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ena;
    logic [1:0]  tag;
    logic [4:0]  addr;
  } iss_t;

  iss_t log_a [NE];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h, want %h", name, edge_n, act, exp);
    end
  endtask

  // Reference model built from the IEEE ordering rules
  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit m_zero(input logic [31:0] x);
    return x[30:0] == 0;
  endfunction

  function automatic bit m_lt(input logic [31:0] a, input logic [31:0] b);
    if (m_zero(a) && m_zero(b)) return 0;
    if (a[31] != b[31])         return a[31];
    if (!a[31])                 return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  function automatic bit m_eq(input logic [31:0] a, input logic [31:0] b);
    return (m_zero(a) && m_zero(b)) || (a == b);
  endfunction

  function automatic logic [31:0] m_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bit nan_any;
    nan_any = m_nan(a) || m_nan(b);
    case (o)
      4'd0: return a;
      4'd1: return a ^ 32'h8000_0000;
      4'd2: return a & 32'h7FFF_FFFF;
      4'd3, 4'd4: begin
        if (m_nan(a) && m_nan(b)) return 32'h7FC0_0000;
        if (m_nan(a))             return b;
        if (m_nan(b))             return a;
        if (m_zero(a) && m_zero(b)) begin
          if (o == 4'd3) return (a[31] || b[31]) ? 32'h8000_0000 : 32'h0;
          return (a[31] && b[31]) ? 32'h8000_0000 : 32'h0;
        end
        if (o == 4'd3) return m_lt(a, b) ? a : b;
        return m_lt(a, b) ? b : a;
      end
      4'd5: return {31'd0, !nan_any && m_eq(a, b)};
      4'd6: return {31'd0, !nan_any && m_lt(a, b)};
      4'd7: return {31'd0, !nan_any && (m_lt(a, b) || m_eq(a, b))};
      default: return 32'd0;
    endcase
  endfunction

  // Two DUT lanes with per-lane monitor
  for (genvar k = 0; k < 2; k++) begin : g_lane
    localparam int D = (k == 0) ? 3 : 8;

    eco32_core_fpu_pipe_if #(.CNT_W(4)) bus ();

    assign bus.i_stb         = stb;
    assign bus.i_tid         = tid;
    assign bus.i_op          = op;
    assign bus.i_r0_data     = ra;
    assign bus.i_r1_data     = rb;
    assign bus.i_ry_ena      = ena;
    assign bus.i_ry_addr     = addr;
    assign bus.i_ry_tag      = tag;
    assign bus.fci_inst_rep  = rep;
    assign bus.fci_inst_skip = skip;
    assign bus.fci_inst_lsf  = lsf;

    eco32_core_fpu_pipe #(.DEPTH(D), .CNT_W(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .fpu (bus)
    );

    initial begin : mon
      forever begin
        int   n, ca, cb, qs;
        bit   due;
        exp_t f;
        @(negedge clk);
        n  = edge_n;
        ca = 0;
        cb = 0;
        for (int e = n - D + 1; e <= n; e++) begin
          if (e >= 0 && log_a[e].acc && !(log_a[e].kill && e < n)) begin
            if (log_a[e].tid) cb++;
            else              ca++;
          end
        end
        check($sformatf("d%0d pendA", D), 64'(bus.o_pendA), 64'(ca));
        check($sformatf("d%0d pendB", D), 64'(bus.o_pendB), 64'(cb));
        check($sformatf("d%0d busy", D), {bus.o_busyA, bus.o_busyB}, {ca != 0, cb != 0});
        check($sformatf("d%0d ill", D), 64'(bus.o_ill), 64'(log_a[n].ill));

        qs  = (k == 0) ? exp_q3.size() : exp_q8.size();
        due = 0;
        f   = '0;
        if (qs > 0) begin
          f   = (k == 0) ? exp_q3[0] : exp_q8[0];
          due = (int'(f.e) + D - 1) <= n;
        end
        check($sformatf("d%0d wb_stb0", D), 64'(bus.wb_stb0), 64'(due));
        if (due) begin
          if (k == 0) void'(exp_q3.pop_front());
          else        void'(exp_q8.pop_front());
          if (bus.wb_stb0) begin
            check($sformatf("d%0d wb_dataL", D), 64'(bus.wb_dataL), 64'(f.data));
            check($sformatf("d%0d wb_ctrl", D),
                  {bus.wb_stb1, bus.wb_enaA, bus.wb_tagA, bus.wb_enaB, bus.wb_tagB, bus.wb_modB, bus.wb_addr},
                  {1'b1, f.ena_a, f.tag_a, f.ena_b, f.tag_b, 1'b0, f.addr});
            check($sformatf("d%0d wb_dataH", D), 64'(bus.wb_dataH), 64'd0);
          end
        end else if (!bus.wb_stb0) begin
          check($sformatf("d%0d idle_wb", D),
                {bus.wb_stb1, bus.wb_enaA, bus.wb_tagA, bus.wb_enaB, bus.wb_tagB, bus.wb_modB,
                 bus.wb_addr, bus.wb_dataL | bus.wb_dataH}, 64'd0);
        end
      end
    end
  end

  // Driver: called at posedge+1 with the cycle's inputs already set.
  task automatic cyc();
    int   n;
    exp_t x;
    n = edge_n;
    if (log_a[n].acc) begin
      if (lsf) begin
        log_a[n].kill = 1;
      end else if (|log_a[n].ena) begin
        x.e     = 32'(n);
        x.ena_a = log_a[n].tid ? 2'b00 : log_a[n].ena;
        x.ena_b = log_a[n].tid ? log_a[n].ena : 2'b00;
        x.tag_a = log_a[n].tag[0];
        x.tag_b = log_a[n].tag[1];
        x.addr  = log_a[n].addr;
        x.data  = m_res(log_a[n].op, log_a[n].a, log_a[n].b);
        exp_q3.push_back(x);
        exp_q8.push_back(x);
      end
    end
    log_a[n+1].acc  = stb && !rep && !skip && (op < 4'd8);
    log_a[n+1].ill  = stb && !rep && !skip && (op >= 4'd8);
    log_a[n+1].kill = 0;
    log_a[n+1].tid  = tid;
    log_a[n+1].op   = op;
    log_a[n+1].a    = ra;
    log_a[n+1].b    = rb;
    log_a[n+1].ena  = ena;
    log_a[n+1].tag  = tag;
    log_a[n+1].addr = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic t, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] en, input logic [4:0] ad, input logic [1:0] tg,
                       input logic rp, input logic sk, input logic ls);
    stb = s; tid = t; op = o; ra = a; rb = b; ena = en; addr = ad; tag = tg;
    rep = rp; skip = sk; lsf = ls;
    cyc();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    stb = 0; rep = 0; skip = 0; lsf = 0;
    for (int e = 0; e <= edge_n + 1 && e < NE; e++) begin
      log_a[e].acc = 0;
      log_a[e].ill = 0;
    end
    exp_q3.delete();
    exp_q8.delete();
    #1;
    check("rst_now d3", {g_lane[0].bus.wb_stb0, g_lane[0].bus.o_pendA, g_lane[0].bus.o_pendB,
                         g_lane[0].bus.wb_dataL}, 64'd0);
    check("rst_now d8", {g_lane[1].bus.wb_stb0, g_lane[1].bus.o_pendA, g_lane[1].bus.o_pendB,
                         g_lane[1].bus.wb_dataL}, 64'd0);
    @(posedge clk);
    #1;
    idle(1);
    rst = 0;
  endtask

  logic [31:0] specials [10] = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                                  32'h7FC0_0000, 32'h7FC0_0001, 32'hFF80_0001, 32'h7F80_0000,
                                  32'hFF80_0000, 32'h4000_0000};

  function automatic logic [31:0] rnd_val();
    if ($urandom_range(0, 2) == 0) return $urandom();
    return specials[$urandom_range(0, 9)];
  endfunction

  initial begin
    logic [31:0] va, vb;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;

    // FNEG latency and routing, then min/max/compare corner cases
    issue(1, 0, OP_FNEG, 32'h3F80_0000, 32'h0, 2'b01, 5'd5, 2'b00, 0, 0, 0);
    issue(1, 0, OP_FMIN, 32'h7FC0_0001, 32'h4000_0000, 2'b11, 5'd1, 2'b01, 0, 0, 0);
    issue(1, 1, OP_FMAX, 32'h8000_0000, 32'h0000_0000, 2'b10, 5'd2, 2'b10, 0, 0, 0);
    issue(1, 0, OP_FCEQ, 32'h8000_0000, 32'h0000_0000, 2'b01, 5'd3, 2'b11, 0, 0, 0);
    issue(1, 1, OP_FCLT, 32'h7FC0_0000, 32'h3F80_0000, 2'b01, 5'd4, 2'b00, 0, 0, 0);
    issue(1, 0, OP_FMIN, 32'h0000_0000, 32'h8000_0000, 2'b01, 5'd6, 2'b00, 0, 0, 0);
    issue(1, 1, OP_FMAX, 32'h7FC0_0001, 32'hFF80_0001, 2'b01, 5'd7, 2'b00, 0, 0, 0);
    issue(1, 0, OP_FABS, 32'hFFC0_0123, 32'h0, 2'b01, 5'd8, 2'b00, 0, 0, 0);
    issue(1, 0, OP_FMOV, 32'h1234_5678, 32'h0, 2'b00, 5'd9, 2'b00, 0, 0, 0);
    idle(10);

    // Replay on the 2nd, stage-1 kill on the 3rd
    issue(1, 1, OP_FMOV, 32'h1111_1111, 32'h0, 2'b11, 5'd10, 2'b11, 0, 0, 0);
    issue(1, 1, OP_FMOV, 32'h2222_2222, 32'h0, 2'b11, 5'd11, 2'b11, 1, 0, 0);
    issue(1, 1, OP_FMOV, 32'h3333_3333, 32'h0, 2'b11, 5'd12, 2'b11, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(10);

    // Reserved opcode and skipped instruction
    issue(1, 0, 4'd9, 32'h3F80_0000, 32'h0, 2'b01, 5'd13, 2'b00, 0, 0, 0);
    issue(1, 1, OP_FMOV, 32'h3F80_0000, 32'h0, 2'b01, 5'd14, 2'b00, 0, 1, 0);
    idle(10);

    // Back-to-back, alternating threads
    for (int i = 0; i < 20; i++)
      issue(1, i[0], 4'($urandom_range(0, 7)), rnd_val(), rnd_val(),
            2'($urandom_range(1, 3)), 5'(i), 2'($urandom_range(0, 3)), 0, 0, 0);
    idle(12);

    // Reset with entries in flight
    for (int i = 0; i < 3; i++)
      issue(1, i[0], OP_FMOV, 32'hCAFE_0000 + 32'(i), 32'h0, 2'b11, 5'(20 + i), 2'b01, 0, 0, 0);
    do_reset();
    idle(12);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      va = rnd_val();
      vb = ($urandom_range(0, 7) == 0) ? va : rnd_val();
      issue($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
            va, vb, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    end
    idle(12);

    check("drain d3", 64'(exp_q3.size()), 64'd0);
    check("drain d8", 64'(exp_q8.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eco32_core_fpu_pipe.md
ECO32_CORE_FPU_PIPE -- requirements
Module: eco32_core_fpu_pipe

Interface
REQ-001 Parameter DEPTH, default 3, write-back latency in cycles from i_stb; legal 3..8.
REQ-002 Parameter CNT_W, default 4, in-flight counter width; must be >= clog2(DEPTH+1), checked at elaboration.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_stb  in  1  instruction valid from IDU; i_tid in 1 thread id (0=A, 1=B); i_op in 4 opcode.
REQ-006 i_r0_data, i_r1_data  in  32 each  operands a, b (IEEE-754 single).
REQ-007 i_ry_ena in 2, i_ry_addr in 5, i_ry_tag in 2: destination enables, address, per-thread tag.
REQ-008 fci_inst_rep, fci_inst_skip, fci_inst_lsf  in  1 each  cancel qualifiers.
REQ-009 wb_stb0, wb_stb1 out 1; wb_enaA out 2, wb_tagA out 1; wb_enaB out 2, wb_tagB out 1, wb_modB out 1; wb_addr out 5; wb_dataL, wb_dataH out 32.
REQ-010 o_pendA, o_pendB  out  CNT_W  in-flight count per thread; o_busyA, o_busyB out 1 = count nonzero.
REQ-011 o_ill  out  1  one-cycle pulse: reserved opcode accepted at stage 0.

Function
REQ-012 Stage 0 SHALL capture valid = i_stb && !fci_inst_rep && !fci_inst_skip && opcode legal.
REQ-013 Stage 1 SHALL kill the entry when fci_inst_lsf is high in that cycle; killed entries produce no write-back.
REQ-014 Stage 1 SHALL compute the result; stages 2..DEPTH-1 SHALL delay it unchanged; write-back outputs are registered from stage DEPTH-1.
REQ-015 Opcodes: 0 FMOV=a; 1 FNEG=a with sign flipped; 2 FABS=a with sign cleared; 3 FMIN; 4 FMAX; 5 FCEQ; 6 FCLT; 7 FCLE; 8..15 reserved.
REQ-016 FNEG/FABS/FMOV SHALL be bitwise, NaN payload preserved.
REQ-017 FMIN/FMAX: one NaN operand returns the other; both NaN returns 0x7FC00000; min(-0,+0)=0x80000000, max(-0,+0)=0x00000000.
REQ-018 Compares: result 1 or 0 in wb_dataL; any NaN operand gives 0; +0 equals -0.
REQ-019 wb_dataH SHALL be 0 for all opcodes.
REQ-020 On valid write-back with |ry_ena: wb_stb0=wb_stb1=1; wb_enaA=ry_ena if tid=0 else 0; wb_enaB=ry_ena if tid=1 else 0; wb_tagA=ry_tag[0], wb_tagB=ry_tag[1], wb_modB=0.
REQ-021 Valid entry with ry_ena=0 SHALL still retire (counter decrement) with wb_stb0/1 low.
REQ-022 Counter of thread t SHALL increment when a stage-0 entry of t becomes valid and decrement when an entry of t is killed at stage 1 or retires at stage DEPTH-1.
REQ-023 Simultaneous increment and decrement(s) on one thread SHALL net correctly (+1-1=0, +1-2=-1 impossible by construction not required).
REQ-024 Back-to-back issue every cycle SHALL be sustained; no stall, no backpressure.
REQ-025 Outputs with no valid write-back: all wb_* zero.

Reset
REQ-026 rst SHALL clear all stage valids, counters, o_ill and every output to 0 immediately; in-flight entries are discarded, not written back.
REQ-027 First instruction accepted in the first rising edge after rst deasserts.

Structure
REQ-028 Package eco32_core_fpu_pkg SHALL hold opcode constants, canonical NaN 0x7FC00000 and the min/max DEPTH bounds.
REQ-029 Sub-module eco32_core_fpu_dly (parametrised width/depth register delay with per-stage valid, async reset) SHALL implement stages 2..DEPTH-1.
REQ-030 Compare and min/max logic SHALL share one magnitude/sign comparator.

Verification
REQ-031 DEPTH=3, FNEG a=0x3F800000, tid=0, ry_ena=2'b01, addr=5 -> 3 cycles later wb_dataL=0xBF800000, wb_enaA=01, wb_enaB=00, wb_addr=5, wb_stb0/1=1.
REQ-032 FMIN a=0x7FC00001, b=0x40000000 -> 0x40000000; FMAX a=0x80000000, b=0x00000000 -> 0x00000000; FCEQ same -> 1; FCLT NaN,1.0 -> 0.
REQ-033 Issue 3 on tid=1 with fci_inst_rep high on 2nd and fci_inst_lsf high one cycle after 3rd -> exactly one write-back (1st); o_pendB peaks 2, returns 0.
REQ-034 DEPTH=8, issue every cycle for 20 cycles alternating tid -> o_pendA=o_pendB=4 steady, 20 write-backs in order, no gaps.
REQ-035 Assert rst with 3 entries in flight -> outputs 0 same cycle, o_pend 0, no write-back after release.
REQ-036 i_op=9 with i_stb -> o_ill pulse one cycle later, no write-back, counters unchanged.
